// File: rtl/unsigned_16by8_seq_div_if.sv
// unsigned_16by8_seq_div_if: operand/result handshake bundle for the sequential divider
interface unsigned_16by8_seq_div_if #(parameter int N = 8);
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] z;
    logic [N-1:0]   y;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   x;
    logic [N-1:0]   r;
    logic           ovf;
    logic           div0;
    modport master (
        output in_valid, z, y, out_ready,
        input  in_ready, out_valid, x, r, ovf, div0
    );
    modport slave (
        input  in_valid, z, y, out_ready,
        output in_ready, out_valid, x, r, ovf, div0
    );
endinterface

// File: rtl/unsigned_16by8_seq_div.sv
// unsigned_16by8_seq_div: radix-2 restoring divider, 2N-bit dividend by N-bit divisor,
// one quotient bit per cycle, one operation in flight.
module unsigned_16by8_seq_div #(parameter int N = 8) (
    input logic clk,
    input logic rst_n,
    unsigned_16by8_seq_div_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, next;
    logic [CW-1:0] cnt;
    logic [N-1:0] rem, lo, q, yr, rem_nx;
    logic [N+1:0] trial;
    logic neg, last, accept, consume, ovf_chk;
    // Trial is one bit wider than {rem,bit} so its MSB is a true sign
    always_comb begin
        accept  = bus.in_valid && bus.in_ready;
        consume = bus.out_valid && bus.out_ready;
        ovf_chk = bus.z[2*N-1:N] >= bus.y;
        trial   = {1'b0, rem, lo[N-1]} - {2'b0, yr};
        neg     = trial[N+1];
        rem_nx  = neg ? {rem[N-2:0], lo[N-1]} : trial[N-1:0];
        last    = cnt == CW'(N-1);
        next    = state;
        case (state)
            IDLE:    next = accept ? (ovf_chk ? DONE : RUN) : IDLE;
            RUN:     next = last ? DONE : RUN;
            DONE:    next = consume ? IDLE : DONE;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            rem           <= '0;
            lo            <= '0;
            q             <= '0;
            yr            <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.x         <= '0;
            bus.r         <= '0;
            bus.ovf       <= 1'b0;
            bus.div0      <= 1'b0;
        end else begin
            bus.in_ready  <= state == IDLE && next == IDLE;
            // Overflow results reach DONE one edge early; out_valid follows a cycle later
            bus.out_valid <= (state == RUN && last) || (state == DONE && !consume);
            if (state == IDLE && accept) begin
                yr  <= bus.y;
                rem <= bus.z[2*N-1:N];
                lo  <= bus.z[N-1:0];
                cnt <= '0;
                if (ovf_chk) begin
                    bus.x    <= '1;
                    bus.r    <= '0;
                    bus.ovf  <= 1'b1;
                    bus.div0 <= bus.y == '0;
                end
            end
            if (state == RUN) begin
                rem <= rem_nx;
                lo  <= {lo[N-2:0], 1'b0};
                q   <= {q[N-2:0], ~neg};
                cnt <= cnt + 1'b1;
                if (last) begin
                    bus.x    <= {q[N-2:0], ~neg};
                    bus.r    <= rem_nx;
                    bus.ovf  <= 1'b0;
                    bus.div0 <= 1'b0;
                end
            end
        end
    end
endmodule
